// File: rtl/mul_div_ctrl_pkg.sv
// Shared definitions for the execute-stage multiply/divide sequencer:
// op bit indices, fixed state encodings and the divide step count.
package mul_div_ctrl_pkg;

  localparam int unsigned MD_MUL    = 0;
  localparam int unsigned MD_MULH   = 1;
  localparam int unsigned MD_DIV    = 2;
  localparam int unsigned MD_MOD    = 3;
  localparam int unsigned DIV_STEPS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_MUL  = 2'd0,
    OP_MULH = 2'd1,
    OP_DIV  = 2'd2,
    OP_MOD  = 2'd3
  } md_kind_t;

  // Lowest set bit of the op vector selects the operation.
  function automatic md_kind_t pick_op(input logic [3:0] op);
    if (op[MD_MUL])       return OP_MUL;
    else if (op[MD_MULH]) return OP_MULH;
    else if (op[MD_DIV])  return OP_DIV;
    else                  return OP_MOD;
  endfunction

endpackage

// File: rtl/mul_div_ctrl_div_iter.sv
// One restoring-division step: shift the next dividend bit into the
// remainder, subtract the divisor when it fits, shift in the quotient bit.
module div_iter #(
  parameter int unsigned DATA_WD = 32
) (
  input  logic [DATA_WD:0]   remainder,
  input  logic [DATA_WD-1:0] quotient,
  input  logic [DATA_WD-1:0] divisor,
  input  logic               en,
  input  logic               init,
  output logic [DATA_WD:0]   remainder_next,
  output logic [DATA_WD-1:0] quotient_next
);

  logic [DATA_WD+1:0] shifted;
  logic [DATA_WD:0]   diff;
  logic               fits;

  always_comb begin
    shifted        = {remainder, quotient[DATA_WD-1]};
    fits           = (shifted >= {2'b00, divisor});
    diff           = shifted[DATA_WD:0] - {1'b0, divisor};
    remainder_next = remainder;
    quotient_next  = quotient;
    if (init) begin
      // quotient carries the dividend magnitude in on the init cycle
      remainder_next = '0;
    end else if (en) begin
      remainder_next = fits ? diff : shifted[DATA_WD:0];
      quotient_next  = {quotient[DATA_WD-2:0], fits};
    end
  end

endmodule

// File: rtl/mul_div_ctrl.sv
// Execute-stage multiply/divide sequencer: latches operands on issue, runs a
// fixed-latency multiply or a 32-step divide, and holds the result for es.
module mul_div_ctrl
  import mul_div_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WD = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic [5:0]         stall,
  input  logic [3:0]         mul_div_op,
  input  logic               mul_div_sign,
  input  logic [DATA_WD-1:0] a,
  input  logic [DATA_WD-1:0] b,
  output logic               stallreq,
  output logic [DATA_WD-1:0] mul_div_result
);

  state_t               state, state_n;
  md_kind_t             op_reg, new_kind, cur_kind;
  logic [5:0]           cnt, cnt_n;
  logic [DATA_WD-1:0]   a_reg, b_reg, dsr_reg, quo_reg, quo_n, quo_in;
  logic [DATA_WD:0]     rem_reg, rem_n;
  logic [DATA_WD-1:0]   result_reg, result_n;
  logic                 sign_reg;
  logic                 issue, iter_en, iter_init;
  logic [DATA_WD-1:0]   mag_a, mag_b;
  logic [DATA_WD-1:0]   cur_a, cur_b;
  logic                 cur_sign;
  logic [2*DATA_WD-1:0] ext_a, ext_b, prod;
  logic [DATA_WD-1:0]   mul_res, div_res, q_fix, r_fix;
  logic                 sa, sb, div_zero;
  logic                 unused_stall;

  assign unused_stall = ^{stall[5:4], stall[2:0]};
  assign new_kind     = pick_op(mul_div_op);

  assign mag_a = (mul_div_sign && a[DATA_WD-1]) ? ('0 - a) : a;
  assign mag_b = (mul_div_sign && b[DATA_WD-1]) ? ('0 - b) : b;

  // Live operands feed the multiplier on the issue cycle so MUL_LAT=1 works.
  always_comb begin
    if (state == ST_IDLE) begin
      cur_a    = a;
      cur_b    = b;
      cur_sign = mul_div_sign;
      cur_kind = new_kind;
    end else begin
      cur_a    = a_reg;
      cur_b    = b_reg;
      cur_sign = sign_reg;
      cur_kind = op_reg;
    end
  end

  assign ext_a   = {{DATA_WD{cur_sign & cur_a[DATA_WD-1]}}, cur_a};
  assign ext_b   = {{DATA_WD{cur_sign & cur_b[DATA_WD-1]}}, cur_b};
  assign prod    = ext_a * ext_b;
  assign mul_res = (cur_kind == OP_MULH) ? prod[2*DATA_WD-1:DATA_WD] : prod[DATA_WD-1:0];

  assign sa       = sign_reg & a_reg[DATA_WD-1];
  assign sb       = sign_reg & b_reg[DATA_WD-1];
  assign div_zero = (dsr_reg == '0);
  assign q_fix    = (sa ^ sb) ? ('0 - quo_reg) : quo_reg;
  assign r_fix    = sa ? ('0 - rem_reg[DATA_WD-1:0]) : rem_reg[DATA_WD-1:0];

  always_comb begin
    if (op_reg == OP_MOD) div_res = div_zero ? a_reg : r_fix;
    else                  div_res = div_zero ? '1 : q_fix;
  end

  assign quo_in = iter_init ? mag_a : quo_reg;

  div_iter #(.DATA_WD(DATA_WD)) u_div_iter (
    .remainder      (rem_reg),
    .quotient       (quo_in),
    .divisor        (dsr_reg),
    .en             (iter_en),
    .init           (iter_init),
    .remainder_next (rem_n),
    .quotient_next  (quo_n)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    result_n  = result_reg;
    issue     = 1'b0;
    iter_en   = 1'b0;
    iter_init = 1'b0;
    stallreq  = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((|mul_div_op) && !flush) begin
          issue    = 1'b1;
          stallreq = 1'b1;
          if (new_kind == OP_MUL || new_kind == OP_MULH) begin
            if (MUL_LAT <= 1) begin
              state_n  = ST_DONE;
              result_n = mul_res;
            end else begin
              state_n = ST_MUL;
              cnt_n   = 6'(MUL_LAT - 1);
            end
          end else begin
            state_n   = ST_DIV;
            cnt_n     = 6'(DIV_STEPS);
            iter_init = 1'b1;
          end
        end
      end
      ST_MUL: begin
        stallreq = 1'b1;
        if (cnt <= 6'd1) begin
          state_n  = ST_DONE;
          cnt_n    = '0;
          result_n = mul_res;
        end else begin
          cnt_n = cnt - 6'd1;
        end
      end
      ST_DIV: begin
        stallreq = 1'b1;
        if (cnt != '0) begin
          iter_en = 1'b1;
          cnt_n   = cnt - 6'd1;
        end else begin
          state_n  = ST_DONE;
          result_n = div_res;
        end
      end
      ST_DONE: begin
        if (!stall[3]) begin
          state_n  = ST_IDLE;
          result_n = '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (flush) begin
      state_n  = ST_IDLE;
      cnt_n    = '0;
      result_n = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      result_reg <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      dsr_reg    <= '0;
      sign_reg   <= 1'b0;
      op_reg     <= OP_MUL;
      rem_reg    <= '0;
      quo_reg    <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      result_reg <= result_n;
      rem_reg    <= rem_n;
      quo_reg    <= quo_n;
      if (issue) begin
        a_reg    <= a;
        b_reg    <= b;
        dsr_reg  <= mag_b;
        sign_reg <= mul_div_sign;
        op_reg   <= new_kind;
      end
    end
  end

  assign mul_div_result = (state == ST_DONE) ? result_reg : '0;

endmodule

// File: tb/tb_mul_div_ctrl.sv
// Directed bench for mul_div_ctrl: latency, results, hold in DONE, aborts.
module tb_mul_div_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic [5:0]  stall;
  logic [3:0]  mul_div_op;
  logic        mul_div_sign;
  logic [31:0] a, b;
  logic        stallreq;
  logic [31:0] mul_div_result;

  int unsigned tests = 0;
  int unsigned fails = 0;

  mul_div_ctrl #(.DATA_WD(32), .MUL_LAT(2)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .flush          (flush),
    .stall          (stall),
    .mul_div_op     (mul_div_op),
    .mul_div_sign   (mul_div_sign),
    .a              (a),
    .b              (b),
    .stallreq       (stallreq),
    .mul_div_result (mul_div_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE, count stallreq cycles, check the DONE result;
  // optionally hold DONE with stall[3] for three extra cycles.
  task automatic run_op(input string tag, input logic [3:0] op, input logic sg,
                        input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] exp_res, input int unsigned exp_cyc,
                        input bit hold);
    int unsigned n;
    @(negedge clk);
    chk({tag, "_idle_res"}, mul_div_result, 32'h0);
    mul_div_op   = op;
    mul_div_sign = sg;
    a            = va;
    b            = vb;
    #1;
    chk({tag, "_issue_stall"}, {31'b0, stallreq}, 32'h1);
    n = 1;
    @(negedge clk);
    mul_div_op   = 4'b0;
    mul_div_sign = ~sg;
    a            = $urandom;
    b            = $urandom;
    while (stallreq === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_cycles"}, n, exp_cyc);
    chk({tag, "_result"}, mul_div_result, exp_res);
    if (hold) begin
      stall = 6'b001000;
      repeat (3) begin
        @(negedge clk);
        chk({tag, "_hold_res"}, mul_div_result, exp_res);
        chk({tag, "_hold_stall"}, {31'b0, stallreq}, 32'h0);
      end
      stall = 6'b0;
    end
  endtask

  initial begin
    resetn       = 1'b0;
    flush        = 1'b0;
    stall        = 6'b0;
    mul_div_op   = 4'b0;
    mul_div_sign = 1'b0;
    a            = 32'h0;
    b            = 32'h0;
    #1;
    chk("reset_stallreq", {31'b0, stallreq}, 32'h0);
    chk("reset_result", mul_div_result, 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    run_op("mul_signed",   4'b0001, 1'b1, 32'hFFFFFFFD, 32'h7,        32'hFFFFFFEB, 2,  1'b0);
    run_op("mulh_unsigned",4'b0010, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2,  1'b0);
    run_op("mulh_signed",  4'b0010, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2,  1'b0);
    run_op("div_signed",   4'b0100, 1'b1, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 34, 1'b0);
    run_op("mod_signed",   4'b1000, 1'b1, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 34, 1'b0);
    run_op("div_by_zero",  4'b0100, 1'b0, 32'h5,        32'h0,        32'hFFFFFFFF, 34, 1'b0);
    run_op("mod_by_zero",  4'b1000, 1'b0, 32'h5,        32'h0,        32'h00000005, 34, 1'b0);
    run_op("smod_by_zero", 4'b1000, 1'b1, 32'hFFFFFFFB, 32'h0,        32'hFFFFFFFB, 34, 1'b0);
    run_op("div_ovf",      4'b0100, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34, 1'b0);
    run_op("mod_ovf",      4'b1000, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34, 1'b0);
    run_op("udiv_big",     4'b0100, 1'b0, 32'hFFFFFFFF, 32'h2,        32'h7FFFFFFF, 34, 1'b0);
    run_op("umod_100_7",   4'b1000, 1'b0, 32'd100,      32'd7,        32'd2,        34, 1'b0);
    run_op("multi_hot_mulh",4'b0110,1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2,  1'b0);
    run_op("multi_hot_div",4'b1100, 1'b0, 32'd100,      32'd7,        32'd14,       34, 1'b0);

    // DONE held by stall[3], then a DIV issued on the first IDLE cycle
    run_op("hold_div",     4'b0100, 1'b0, 32'd100,      32'd7,        32'd14,       34, 1'b1);
    run_op("after_hold",   4'b0100, 1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, 1'b0);

    // flush at S+10 of a DIV
    @(negedge clk);
    mul_div_op = 4'b0100; mul_div_sign = 1'b0; a = 32'd100; b = 32'd7;
    repeat (10) begin
      @(negedge clk);
      mul_div_op = 4'b0;
    end
    chk("flush_pre_stall", {31'b0, stallreq}, 32'h1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_stallreq", {31'b0, stallreq}, 32'h0);
    chk("flush_result", mul_div_result, 32'h0);
    run_op("after_flush",  4'b0001, 1'b0, 32'd6,        32'd7,        32'd42,       2,  1'b0);

    // asynchronous reset at S+20 of a DIV
    @(negedge clk);
    mul_div_op = 4'b0100; mul_div_sign = 1'b0; a = 32'd100; b = 32'd7;
    repeat (20) begin
      @(negedge clk);
      mul_div_op = 4'b0;
    end
    chk("rst_pre_stall", {31'b0, stallreq}, 32'h1);
    resetn = 1'b0;
    #1;
    chk("rst_mid_stallreq", {31'b0, stallreq}, 32'h0);
    chk("rst_mid_result", mul_div_result, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    run_op("after_reset",  4'b1000, 1'b0, 32'd100,      32'd7,        32'd2,        34, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
